// File: rtl/clock_pkg.sv
// Shared encodings for the digital-clock set controller.
// Field-select states and display blank-mask bit positions.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } st_t;

    localparam int BLK_HOUR = 2;
    localparam int BLK_MIN  = 1;
    localparam int BLK_SEC  = 0;

endpackage

// File: rtl/key_repeat.sv
// Increment-key edge detect with long-press auto-repeat.
// Emits one strobe per press and per repeat interval while held.
module key_repeat
    import clock_pkg::*;
#(
    parameter int LONG_PRESS    = 8,
    parameter int REPEAT_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic strobe
);

    localparam int LW = $clog2(LONG_PRESS + 1);
    localparam int RW = $clog2(REPEAT_PERIOD + 1);

    logic          key_d;
    logic          inh;
    logic [LW-1:0] cnt;
    logic [RW-1:0] rep;
    logic          run;
    logic          hit_long;
    logic          hit_rep;

    assign rise     = key & ~key_d;
    assign run      = key & ~inh & en & ~clr;
    assign hit_long = tick && (cnt == LW'(LONG_PRESS - 1));
    assign hit_rep  = tick && (cnt == LW'(LONG_PRESS))
                      && (rep == RW'(REPEAT_PERIOD - 1));
    assign strobe   = en & ~clr & (rise | (run & (hit_long | hit_rep)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_d <= 1'b0;
            inh   <= 1'b0;
            cnt   <= '0;
            rep   <= '0;
        end else begin
            key_d <= key;
            // A held key that sees a mode change stays dead until re-pressed
            if (!key)
                inh <= 1'b0;
            else if (clr)
                inh <= 1'b1;
            if (!run) begin
                cnt <= '0;
                rep <= '0;
            end else if (tick) begin
                if (cnt != LW'(LONG_PRESS))
                    cnt <= cnt + 1'b1;
                else if (rep == RW'(REPEAT_PERIOD - 1))
                    rep <= '0;
                else
                    rep <= rep + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode FSM, idle timeout, blink mask and
// per-field increment strobes for the hour/minute/second counters.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int LONG_PRESS    = 8,
    parameter int REPEAT_PERIOD = 2,
    parameter int TIMEOUT       = 100,
    parameter int BLINK_HALF    = 5
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       tick_10hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       isSetting,
    output logic       sec_run,
    output logic [1:0] sel,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [2:0] blank
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    st_t           state;
    st_t           state_nx;
    logic          mode_d;
    logic          mode_rise;
    logic          in_set;
    logic          to_hit;
    logic          chg;
    logic          inc_rise;
    logic          fire;
    logic [TW-1:0] to_cnt;
    logic [BW-1:0] bl_cnt;
    logic          blink_phase;

    assign in_set    = (state != ST_RUN);
    assign mode_rise = key_mode & ~mode_d;
    assign to_hit    = in_set && (to_cnt == TW'(TIMEOUT));
    assign chg       = (state_nx != state);

    key_repeat #(
        .LONG_PRESS   (LONG_PRESS),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rep (
        .clk   (clk),
        .rst   (CLR_n),
        .tick  (tick_10hz),
        .key   (key_inc),
        .en    (in_set),
        .clr   (chg),
        .rise  (inc_rise),
        .strobe(fire)
    );

    always_comb begin
        state_nx = state;
        if (mode_rise) begin
            unique case (state)
                ST_RUN:      state_nx = ST_SET_HOUR;
                ST_SET_HOUR: state_nx = ST_SET_MIN;
                ST_SET_MIN:  state_nx = ST_SET_SEC;
                ST_SET_SEC:  state_nx = ST_RUN;
            endcase
        end else if (to_hit) begin
            state_nx = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge CLR_n) begin
        if (CLR_n) begin
            state       <= ST_RUN;
            mode_d      <= 1'b0;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            inc_sec     <= 1'b0;
            to_cnt      <= '0;
            bl_cnt      <= '0;
            blink_phase <= 1'b0;
        end else begin
            state    <= state_nx;
            mode_d   <= key_mode;
            inc_hour <= fire && (state == ST_SET_HOUR);
            inc_min  <= fire && (state == ST_SET_MIN);
            inc_sec  <= fire && (state == ST_SET_SEC);
            if (!in_set || chg || mode_rise || inc_rise || fire)
                to_cnt <= '0;
            else if (tick_10hz && to_cnt != TW'(TIMEOUT))
                to_cnt <= to_cnt + 1'b1;
            // Keep the field visible while it is being stepped
            if (!in_set || chg || fire) begin
                bl_cnt      <= '0;
                blink_phase <= 1'b0;
            end else if (tick_10hz) begin
                if (bl_cnt == BW'(BLINK_HALF - 1)) begin
                    bl_cnt      <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bl_cnt <= bl_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        blank           = '0;
        blank[BLK_HOUR] = (state == ST_SET_HOUR) & blink_phase;
        blank[BLK_MIN]  = (state == ST_SET_MIN) & blink_phase;
        blank[BLK_SEC]  = (state == ST_SET_SEC) & blink_phase;
    end

    assign sel       = state;
    assign isSetting = in_set;
    assign sec_run   = (state != ST_SET_SEC);

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-setting controller for the digital-clock datapath (hour/minute/second mod-N counter chain).
- Steps through the field-select modes and drives the isSetting carry-suppress signal into the counters.
- Issues single-cycle increment strobes to the selected field, with auto-repeat on a held key.
- Generates the blink mask for the display and returns to run mode after an idle timeout.

Parameters:
- LONG_PRESS, 8: tick_10hz periods key_inc must be held before auto-repeat starts (0.8 s).
- REPEAT_PERIOD, 2: tick_10hz periods between auto-repeat strobes (0.2 s).
- TIMEOUT, 100: tick_10hz periods with no key activity before a set state returns to RUN (10 s).
- BLINK_HALF, 5: tick_10hz periods per blink half-phase (1 Hz blink).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- CLR_n  input  1  asynchronous reset, active-high; the _n suffix does not denote polarity.
- tick_10hz  input  1  one-clk-wide strobe, 10 Hz, synchronous to clk.
- key_mode  input  1  debounced, clk-synchronous mode key level; 1 = pressed.
- key_inc  input  1  debounced, clk-synchronous increment key level; 1 = pressed.
- isSetting  output  1  1 in any SET state; counters suppress their carry-out while it is high.
- sec_run  output  1  seconds timebase enable; 0 in SET_SEC, otherwise 1.
- sel  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- inc_hour  output  1  one-clk increment strobe to the hour counter.
- inc_min  output  1  one-clk increment strobe to the minute counter.
- inc_sec  output  1  one-clk increment strobe to the second counter.
- blank  output  3  display blank mask {hour, min, sec}; 1 = blank that field.

Behaviour:
- Reset (CLR_n = 1, asynchronous):
  - state RUN, sel = 0, isSetting = 0, sec_run = 1.
  - inc_* = 0, blank = 0.
  - All counters (repeat, timeout, blink) = 0; edge-detect flops = 0.
- Edge detect: one flop per key. rise = key & ~key_d. All outputs are registered.
- Mode FSM, on a key_mode rise: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- isSetting = (state != RUN). sec_run = (state != SET_SEC).
- Increment handling (active only in SET states; key_inc is ignored in RUN):
  - Latency: a key_inc rise sampled at edge N gives inc_<sel> = 1 for exactly the cycle following edge N.
  - Held key: the repeat counter advances on tick_10hz while key_inc = 1.
  - At the tick where the count reaches LONG_PRESS, one strobe fires. After that, a strobe fires every REPEAT_PERIOD ticks until release.
  - Release clears the repeat counter immediately.
  - Only the strobe for the selected field fires. At most one inc_* is high in any cycle.
- Simultaneous key_mode rise and key_inc rise in the same cycle: the mode advance wins and the inc strobe is dropped.
- Mode change while key_inc is held: the repeat counter clears and stays inhibited until key_inc is released and pressed again.
- Timeout:
  - The counter advances on tick_10hz in SET states.
  - It clears on any key rise, any inc strobe, and any state change.
  - When it reaches TIMEOUT, the FSM goes to RUN on the next edge; inc is suppressed in that cycle.
  - In RUN the counter is held at 0.
- Blink:
  - The phase counter toggles blink_phase every BLINK_HALF ticks in SET states.
  - On entry to any SET state, counter = 0 and blink_phase = 0 (field visible).
  - blank[field] = (field selected) & blink_phase.
  - blank = 0 in RUN.
  - While any inc strobe fires, blink_phase is forced to 0 so the changing value stays visible.
- Counter widths: $clog2(param+1). Counters saturate and never wrap past their terminal value.
- The block never drives counter values and never checks field range; the counter wrap (for example 5 -> 0 on the tens digit) stays in the datapath.
- A reset asserted mid-press returns to RUN with no strobe. A key still held at reset release is not treated as a rise.

Decomposition:
- Shared package (clock_pkg): state encodings ST_RUN/ST_SET_HOUR/ST_SET_MIN/ST_SET_SEC (2-bit) and the blank-mask bit indices.
- Sub-module key_repeat: edge detect, LONG_PRESS/REPEAT_PERIOD counter, inhibit flag; outputs a single strobe.
- Top level: holds the FSM, timeout, blink, and strobe demux.

Test Plan:
- Reset, then three key_mode pulses -> sel goes 1, 2, 3 with isSetting = 1; sec_run = 0 only at sel = 3; a fourth pulse -> sel = 0, isSetting = 0.
- sel = 2, one short key_inc press -> exactly one inc_min high for 1 clk; inc_hour and inc_sec stay 0.
- sel = 1, key_inc held for 20 ticks -> strobes at press, at tick 8, then at ticks 10, 12, …, 20: 8 total.
- sel = 3 with no keys for 100 ticks -> returns to sel = 0, blank = 0, sec_run = 1; at tick 99 it is still sel = 3.
- key_mode and key_inc rise in the same clk at sel = 1 -> sel = 2 and no inc strobe; key_inc held after that -> no repeats until release and re-press.
- CLR_n pulsed mid-repeat at sel = 2 -> all outputs reset asynchronously; key_inc still high after release -> no strobe.
